// File: rtl/uart_rx_param_if.sv
// Purpose: bundles the serial-line inputs and received-word outputs of uart_rx_param.
// Ports: master = receiver side (takes rx_tick/rx, drives rx_dout, rx_to_fifo, frame_err,
//        parity_err, busy); slave = the line driver / word consumer (the reverse directions).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_dout;
  logic                 rx_to_fifo;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx_tick,
    input  rx,
    output rx_dout,
    output rx_to_fifo,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    output rx_tick,
    output rx,
    input  rx_dout,
    input  rx_to_fifo,
    input  frame_err,
    input  parity_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Purpose: oversampling UART receiver; frame = start, DATA_BITS (LSB first), optional parity, STOP_BITS.
// Ports: clk, rst_n (async active-low), bus (uart_rx_param_if.master: rx_tick, rx in; rx_dout,
//        rx_to_fifo, frame_err, parity_err, busy out). Optional parity bit enabled by `define UART_RX_PARITY_EN.
// Latency: rx_to_fifo pulses 1 clk after the tick sampling the last stop bit; no backpressure (word is dropped if unread).
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_param_if.master bus
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_ONE    = OS_W'(1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic       PAR_ODD_BIT  = (PARITY_ODD != 0);
`endif
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_pend_q, frame_pend_d;
  // Set by the last stop-bit sample; the following clk edge publishes the frame.
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] rx_dout_q, rx_dout_d;
  logic                 rx_to_fifo_q, rx_to_fifo_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_pend_q, parity_pend_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_pend_d = frame_pend_q;
    done_d       = done_q;
    rx_dout_d    = rx_dout_q;
    rx_to_fifo_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_pend_d = parity_pend_q;
    parity_err_d  = 1'b0;
`endif
    if (done_q) begin
      // Completion does not wait for rx_tick.
      done_d       = 1'b0;
      rx_dout_d    = shift_q;
      rx_to_fifo_d = 1'b1;
      frame_err_d  = frame_pend_q;
      frame_pend_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d  = parity_pend_q;
      parity_pend_d = 1'b0;
`endif
      os_cnt_d  = '0;
      bit_cnt_d = '0;
      // A bad stop bit may be a break: wait for the line to go high before hunting a start.
      state_d   = frame_pend_q ? ST_WAIT_HIGH : ST_IDLE;
    end else if (bus.rx_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d  = ST_START;
            os_cnt_d = '0;
          end
        end
        ST_START: begin
          if (os_cnt_q == OS_MID) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        ST_DATA: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = ST_PARITY;
`else
              state_d   = ST_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (rx_s_q != ((^shift_q) ^ PAR_ODD_BIT)) parity_pend_d = 1'b1;
            state_d = ST_STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (!rx_s_q) frame_pend_d = 1'b1;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      frame_pend_q <= 1'b0;
      done_q       <= 1'b0;
      rx_dout_q    <= '0;
      rx_to_fifo_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_pend_q <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= bus.rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      frame_pend_q <= frame_pend_d;
      done_q       <= done_d;
      rx_dout_q    <= rx_dout_d;
      rx_to_fifo_q <= rx_to_fifo_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_pend_q <= parity_pend_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign bus.rx_dout    = rx_dout_q;
  assign bus.rx_to_fifo = rx_to_fifo_q;
  assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Purpose: self-checking bench for uart_rx_param (8 data bits, x16 oversample, 1 stop, tick every clk).
// Ports: none; drives the receiver through a uart_rx_param_if instance, models frames as a queue of expected words.
module tb_uart_rx_param;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam bit ODD = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  uart_rx_param_if #(.DATA_BITS(8)) bus ();

  uart_rx_param #(
    .DATA_BITS (8),
    .OVERSAMPLE(OS),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         fe;
    bit         pe;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] last_dout = 8'h00;
  bit         last_fe = 1'b0;
  bit         last_pe = 1'b0;
  int         pulses = 0;
  bit         prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle out of reset, outputs are checked against the expected-frame queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_to_fifo) begin
        chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
        if (expq.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("rx_dout", {24'd0, bus.rx_dout}, {24'd0, e.d});
          chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e.fe});
          chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
          chk("pulse_timing", {31'd0, (cyc >= e.lo && cyc <= e.hi)}, 32'd1);
          last_dout = e.d;
        end
        last_fe = bus.frame_err;
        last_pe = bus.parity_err;
        pulses++;
      end else begin
        chk("err_flags_idle", {30'd0, bus.frame_err, bus.parity_err}, 32'd0);
        chk("dout_hold", {24'd0, bus.rx_dout}, {24'd0, last_dout});
      end
      prev_pulse = bus.rx_to_fifo;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic line(input logic v, input int n);
    bus.rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit good_par(input logic [7:0] d);
    return (^d) ^ ODD;
  endfunction

  // Sends one whole frame and, if asked, records what the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit pbit,
                            input int gap, input bit push);
    int   nbits;
    exp_t e;
    nbits = 10 + (PAR ? 1 : 0);
    e.d  = d;
    e.fe = !stop_v;
    e.pe = PAR ? (pbit != good_par(d)) : 1'b0;
    // Stop bit is sampled near its middle; the report must land inside the stop bit (sync slack allowed).
    e.lo = cyc + (nbits - 1) * OS + OS / 2 - 2;
    e.hi = cyc + nbits * OS + 2;
    if (push) expq.push_back(e);
    line(1'b0, OS);
    for (int i = 0; i < 8; i++) line(d[i], OS);
    if (PAR) line(pbit, OS);
    line(stop_v, OS);
    if (gap > 0) line(1'b1, gap);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && expq.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, expq.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.rx      = 1'b1;
    bus.rx_tick = 1'b1;
    #3;
    chk("reset_dout", {24'd0, bus.rx_dout}, 32'd0);
    chk("reset_flags", {28'd0, bus.rx_to_fifo, bus.frame_err, bus.parity_err, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    line(1'b1, 4);

    // Single good frame.
    p0 = pulses;
    send_frame(8'hA5, 1'b1, good_par(8'hA5), 10, 1'b1);
    wait_drain("drain_a5");
    chk("a5_value", {24'd0, bus.rx_dout}, 32'h0000_00A5);
    chk("a5_pulses", pulses - p0, 32'd1);
    chk("a5_busy_low", {31'd0, bus.busy}, 32'd0);
    chk("a5_no_ferr", {31'd0, last_fe}, 32'd0);

    // False start: line low for 4 ticks only.
    p0 = pulses;
    line(1'b0, 4);
    line(1'b1, 24);
    chk("false_start_busy", {31'd0, bus.busy}, 32'd0);
    chk("false_start_pulses", pulses - p0, 32'd0);
    chk("false_start_dout", {24'd0, bus.rx_dout}, 32'h0000_00A5);

    // Break: bad stop bit, line held low.
    p0 = pulses;
    send_frame(8'h3C, 1'b0, good_par(8'h3C), 0, 1'b1);
    line(1'b0, 40);
    chk("break_pulses", pulses - p0, 32'd1);
    chk("break_ferr", {31'd0, last_fe}, 32'd1);
    chk("break_busy_held", {31'd0, bus.busy}, 32'd1);
    line(1'b1, 20);
    chk("break_released", {31'd0, bus.busy}, 32'd0);
    chk("break_no_extra", pulses - p0, 32'd1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 10, 1'b1);
    wait_drain("drain_par0");
    chk("par_07_p0", {31'd0, last_pe}, 32'd1);
    send_frame(8'h07, 1'b1, 1'b1, 10, 1'b1);
    wait_drain("drain_par1");
    chk("par_07_p1", {31'd0, last_pe}, 32'd0);
`endif

    // Back-to-back frames with no idle gap.
    p0 = pulses;
    send_frame(8'h00, 1'b1, good_par(8'h00), 0, 1'b1);
    send_frame(8'hFF, 1'b1, good_par(8'hFF), 8, 1'b1);
    wait_drain("drain_b2b");
    chk("b2b_pulses", pulses - p0, 32'd2);
    chk("b2b_last", {24'd0, bus.rx_dout}, 32'h0000_00FF);

    // Reset in the middle of data bit 4 of 0x5A.
    p0 = pulses;
    line(1'b0, OS);
    for (int i = 0; i < 4; i++) line(((8'h5A >> i) & 8'h01) != 0, OS);
    line(1'b1, 8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", {24'd0, bus.rx_dout}, 32'd0);
    chk("midrst_flags", {28'd0, bus.rx_to_fifo, bus.frame_err, bus.parity_err, bus.busy}, 32'd0);
    last_dout = 8'h00;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    line(1'b1, 40);
    chk("midrst_no_pulse", pulses - p0, 32'd0);
    send_frame(8'h81, 1'b1, good_par(8'h81), 10, 1'b1);
    wait_drain("drain_81");
    chk("after_rst_81", {24'd0, bus.rx_dout}, 32'h0000_0081);

    // Randomized frames: data, gaps, occasional bad stop bits and (if enabled) bad parity.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit         sv;
      bit         pb;
      int         gap;
      d   = 8'($urandom_range(0, 255));
      sv  = ($urandom_range(0, 7) != 0);
      pb  = good_par(d) ^ ($urandom_range(0, 3) == 0);
      gap = sv ? int'($urandom_range(0, 20)) : int'($urandom_range(6, 20));
      send_frame(d, sv, pb, gap, 1'b1);
    end
    line(1'b1, 10);
    wait_drain("drain_random");
    chk("random_idle_busy", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: rx_tick pulses per bit period; legal values are even numbers from 8 to 32.
REQ-003 Parameter STOP_BITS, default 1: stop bits checked per frame; legal values are 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; used only when UART_RX_PARITY_EN is defined.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 rx_tick  input  1  oversample enable; a 1-clk pulse, OVERSAMPLE pulses per bit time.
REQ-008 rx  input  1  asynchronous serial line; idles high.
REQ-009 rx_dout  output  DATA_BITS  last received data word, LSB first on the line.
REQ-010 rx_to_fifo  output  1  1-clk pulse when a frame completes; qualifies rx_dout and the error flags.
REQ-011 frame_err  output  1  set with rx_to_fifo when any stop bit samples 0.
REQ-012 parity_err  output  1  set with rx_to_fifo on parity mismatch; tied 0 when parity is disabled.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 rx shall pass through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-015 The FSM shall have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-016 The FSM and the oversample counter os_cnt shall advance only on clk edges with rx_tick=1.
REQ-017 IDLE: on a tick with rx_s=0, enter START with os_cnt=0.
REQ-018 START: increment os_cnt each tick; at os_cnt=OVERSAMPLE/2-1, sample rx_s.
- rx_s=0: enter DATA with os_cnt=0.
- rx_s=1: false start; return to IDLE, no outputs.
REQ-019 DATA: at os_cnt=OVERSAMPLE-1, shift rx_s into the MSB of the shift register (LSB-first) and set os_cnt to 0.
- After DATA_BITS samples: go to PARITY if parity is enabled, else STOP.
REQ-020 PARITY: at os_cnt=OVERSAMPLE-1, sample the parity bit.
- Mismatch against XOR(data) XOR PARITY_ODD latches parity_err_pending.
REQ-021 STOP: at os_cnt=OVERSAMPLE-1, sample each stop bit; any 0 latches frame_err_pending.
- After STOP_BITS samples, the next clk edge (regardless of rx_tick) shall:
  - load rx_dout,
  - pulse rx_to_fifo for exactly 1 clk,
  - drive frame_err and parity_err from the pending flags.
REQ-022 Frame completion transitions:
- No frame error: go to IDLE.
- Frame error: go to WAIT_HIGH, which returns to IDLE on the first tick with rx_s=1 (break handling; no new start is detected while the line is held low).
REQ-023 frame_err and parity_err shall be 0 whenever rx_to_fifo=0; pending flags clear on frame completion.
REQ-024 rx_dout shall hold its value between frames; it is unchanged by false starts.
REQ-025 os_cnt width is $clog2(OVERSAMPLE); bit counter width is 4 bits; no counter wraps outside the transitions above.
REQ-026 Latency: rx_to_fifo rises 1 clk after the tick that samples the last stop bit.
REQ-027 A new start bit shall be accepted on the first tick in IDLE; back-to-back frames are received without loss.

Reset
REQ-028 rst_n=0 shall asynchronously force, regardless of clk:
- state=IDLE, os_cnt=0, bit count=0, shift register=0, pending flags=0;
- rx_dout=0, rx_to_fifo=0, frame_err=0, parity_err=0, busy=0;
- synchronizer flops=1.
REQ-029 Reset mid-frame shall discard the partial frame with no rx_to_fifo pulse.
- Reception resumes with the next start bit after rst_n rises.

Configuration
REQ-030 Macro UART_RX_PARITY_EN shall control parity support.
- Defined: the PARITY state exists and one parity bit follows the data bits.
- Undefined: the PARITY state, parity logic and PARITY_ODD are unused; DATA goes directly to STOP; parity_err is constant 0.

Verification
REQ-031 Setup for all scenarios: DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1, rx_tick every clk.
- Frame 0xA5 -> rx_dout=0xA5, one rx_to_fifo pulse, frame_err=0, busy low afterwards.
REQ-032 rx low for 4 ticks, then high -> returns to IDLE, no rx_to_fifo, rx_dout unchanged.
REQ-033 Frame 0x3C with stop bit 0, line held low for 40 ticks -> rx_to_fifo with frame_err=1.
- FSM remains in WAIT_HIGH until rx rises; no spurious frame.
REQ-034 With UART_RX_PARITY_EN and PARITY_ODD=0: frame 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-035 rst_n asserted during data bit 4 of 0x5A -> outputs zero immediately, no rx_to_fifo.
- A following 0x81 frame is received correctly.
REQ-036 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_to_fifo pulses, values 0x00 then 0xFF.
